run_controller: RTL
===================

// Module: run_controller
// PURPOSE
//  Sits directly downstream of the Y86 processor: consumes its 3-bit status every
//  cycle and produces the processor clock-enable. Starts, pauses, single-steps and
//  stops execution; latches the terminating status, counts executed cycles and
//  enforces a watchdog limit. Its done/halt outputs replace ad-hoc bench polling.
// PARAMETERS
//  CW          32      width of cycle_count
//  MAX_CYCLES  100000  watchdog limit of enabled cycles; 0 disables the watchdog
// PORTS
//  clk          in   1   system clock, all state updates on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   one-cycle pulse: begin execution (honoured in IDLE only)
//  pause        in   1   level: while high in RUN, enter/stay PAUSE
//  step         in   1   one-cycle pulse: in PAUSE, enable exactly one cycle
//  status       in   3   processor stat: 1=AOK 2=HLT 3=ADR 4=INS, other=invalid
//  cpu_en       out  1   clock-enable to processor (registered)
//  running      out  1   high in RUN or PAUSE
//  done         out  1   high in HALT, FAULT or TIMEOUT (sticky until reset)
//  halted       out  1   high only in HALT (clean HLT termination)
//  fault        out  1   high in FAULT or TIMEOUT
//  final_status out  3   status latched at termination; 3'd0 on TIMEOUT
//  cycle_count  out  CW  number of cycles with cpu_en=1 since start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cpu_en=0, running=0, done=0, halted=0,
//   fault=0, final_status=0, cycle_count=0. Reset mid-run aborts immediately.
//  States: IDLE, RUN, PAUSE, STEP, HALT, FAULT, TIMEOUT (one-hot or binary).
//  IDLE: start=1 -> RUN, cpu_en=1 from next cycle, cycle_count cleared to 0.
//  RUN: each edge with cpu_en=1 increments cycle_count (saturates at all-ones).
//   Priority at an edge, highest first:
//   1 status==2 -> HALT, final_status=2
//   2 status in {3,4} or invalid (0,5,6,7) -> FAULT, final_status=status
//   3 MAX_CYCLES!=0 and cycle_count+1==MAX_CYCLES -> TIMEOUT, final_status=0
//   4 pause=1 -> PAUSE
//   5 else stay RUN
//  cpu_en is cleared on the same edge the terminal/pause transition is taken,
//   so the processor sees no further enabled edge after the one that produced
//   the terminal status.
//  PAUSE: cpu_en=0, status still checked (rules 1-2). step=1 -> STEP with
//   cpu_en=1 for exactly one cycle; pause=0 (no step) -> RUN, cpu_en=1 next cycle.
//   step and pause-release in the same cycle: step wins.
//  STEP: one enabled cycle; count increments; next edge applies RUN priority
//   rules 1-3, else returns to PAUSE regardless of pause level.
//  HALT/FAULT/TIMEOUT: terminal, cpu_en=0, outputs frozen; start ignored;
//   only rst_n leaves them.
//  start outside IDLE, step outside PAUSE: ignored, no side effects.
//  Status sampled only in RUN/PAUSE/STEP; ignored in IDLE and terminal states.
//  All outputs are registered; no combinational input-to-output paths.
// TESTING
//  1 reset, start, status=1 for 5 cycles then 2 -> HALT, halted=1, done=1,
//    final_status=2, cycle_count=6, cpu_en=0 on that edge onward.
//  2 start, status=4 on 3rd enabled cycle -> FAULT, fault=1, final_status=4,
//    cycle_count=3; later start pulse has no effect.
//  3 MAX_CYCLES=10, status held 1 -> TIMEOUT after cycle_count=10,
//    final_status=0, fault=1, halted=0.
//  4 RUN, pause=1 at count 4 -> cpu_en=0; three step pulses -> count 7,
//    exactly 3 enabled cycles; pause=0 -> RUN resumes, count increments.
//  5 status=7 (invalid) in RUN -> FAULT, final_status=7; status=2 while paused
//    -> HALT with no enabled cycle.
//  6 rst_n low asynchronously mid-RUN (between edges) -> all outputs zero
//    immediately; after release, start restarts with cycle_count from 0.

Source files
------------

// File: rtl/run_controller_if.sv
// Control/status bundle between the run controller and whatever drives the processor.
// The controller takes the slave side; the stimulus/processor-facing side takes master.
interface run_controller_if #(
    parameter int CW = 32
);
    logic          start;
    logic          pause;
    logic          step;
    logic [2:0]    status;
    logic          cpu_en;
    logic          running;
    logic          done;
    logic          halted;
    logic          fault;
    logic [2:0]    final_status;
    logic [CW-1:0] cycle_count;

    modport master (
        output start, pause, step, status,
        input  cpu_en, running, done, halted, fault, final_status, cycle_count
    );

    modport slave (
        input  start, pause, step, status,
        output cpu_en, running, done, halted, fault, final_status, cycle_count
    );
endinterface

// File: rtl/run_controller.sv
// Run controller for the Y86 processor: gates the processor clock-enable, supports
// pause/single-step, latches the terminating status and enforces a cycle watchdog.
module run_controller #(
    parameter int          CW         = 32,
    parameter int unsigned MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    run_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_STEP,
        S_HALT,
        S_FAULT,
        S_TIMEOUT
    } state_t;

    localparam logic [2:0]  STAT_AOK = 3'd1;
    localparam logic [2:0]  STAT_HLT = 3'd2;
    localparam logic [CW:0] LIMIT    = (CW+1)'(MAX_CYCLES);
    localparam logic [CW:0] ONE_W    = (CW+1)'(1);

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_cpu_en;
    logic          r_running;
    logic          r_done;
    logic          r_halted;
    logic          r_fault;
    logic [2:0]    r_final_status;
    logic [CW-1:0] r_cycle_count;

    logic          w_cpu_en_nxt;
    logic          w_running_nxt;
    logic          w_done_nxt;
    logic          w_halted_nxt;
    logic          w_fault_nxt;
    logic [2:0]    w_final_status_nxt;
    logic [CW-1:0] w_cycle_count_nxt;

    logic          w_stat_hlt;
    logic          w_stat_bad;
    logic          w_limit_hit;
    logic          w_active;
    logic          w_count_sat;

    // Anything other than AOK or HLT (including the undefined encodings) is a fault.
    assign w_stat_hlt  = (bus.status == STAT_HLT);
    assign w_stat_bad  = (bus.status != STAT_AOK) && (bus.status != STAT_HLT);
    assign w_count_sat = &r_cycle_count;

    // The edge being evaluated is itself an enabled one, so compare against count+1.
    assign w_limit_hit = (MAX_CYCLES != 0) && (({1'b0, r_cycle_count} + ONE_W) == LIMIT);

    assign w_active = (r_state == S_RUN) || (r_state == S_PAUSE) || (r_state == S_STEP);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cpu_en       <= 1'b0;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_halted       <= 1'b0;
            r_fault        <= 1'b0;
            r_final_status <= 3'd0;
            r_cycle_count  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cpu_en       <= w_cpu_en_nxt;
            r_running      <= w_running_nxt;
            r_done         <= w_done_nxt;
            r_halted       <= w_halted_nxt;
            r_fault        <= w_fault_nxt;
            r_final_status <= w_final_status_nxt;
            r_cycle_count  <= w_cycle_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of inferred
    // latches on paths that do not assign the state explicitly.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_stat_hlt)       w_state_nxt = S_HALT;
                else if (w_stat_bad)  w_state_nxt = S_FAULT;
                else if (w_limit_hit) w_state_nxt = S_TIMEOUT;
                else if (bus.pause)   w_state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                // Step beats a simultaneous pause release.
                if (w_stat_hlt)      w_state_nxt = S_HALT;
                else if (w_stat_bad) w_state_nxt = S_FAULT;
                else if (bus.step)   w_state_nxt = S_STEP;
                else if (!bus.pause) w_state_nxt = S_RUN;
            end
            S_STEP: begin
                if (w_stat_hlt)       w_state_nxt = S_HALT;
                else if (w_stat_bad)  w_state_nxt = S_FAULT;
                else if (w_limit_hit) w_state_nxt = S_TIMEOUT;
                else                  w_state_nxt = S_PAUSE;
            end
            S_HALT, S_FAULT, S_TIMEOUT: begin
                w_state_nxt = r_state;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: values the output flops take at the coming edge
    // ------------------------------------------------------------------------
    always_comb begin
        // Enable follows the destination state, so it drops on the terminal/pause edge.
        w_cpu_en_nxt  = (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
        // A single-step is still part of a paused run.
        w_running_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE) ||
                        (w_state_nxt == S_STEP);
        w_halted_nxt  = (w_state_nxt == S_HALT);
        w_fault_nxt   = (w_state_nxt == S_FAULT) || (w_state_nxt == S_TIMEOUT);
        w_done_nxt    = w_halted_nxt || w_fault_nxt;

        w_final_status_nxt = r_final_status;
        if (w_active) begin
            if ((w_state_nxt == S_HALT) || (w_state_nxt == S_FAULT))
                w_final_status_nxt = bus.status;
            else if (w_state_nxt == S_TIMEOUT)
                w_final_status_nxt = 3'd0;
        end

        w_cycle_count_nxt = r_cycle_count;
        if ((r_state == S_IDLE) && (w_state_nxt == S_RUN))
            w_cycle_count_nxt = '0;
        else if (r_cpu_en && !w_count_sat)
            w_cycle_count_nxt = r_cycle_count + 1'b1;
    end

    assign bus.cpu_en       = r_cpu_en;
    assign bus.running      = r_running;
    assign bus.done         = r_done;
    assign bus.halted       = r_halted;
    assign bus.fault        = r_fault;
    assign bus.final_status = r_final_status;
    assign bus.cycle_count  = r_cycle_count;

endmodule
